sramlike_mem_responder: RTL and testbench

//  Slave (responder) end of the SRAM-like ben/din/dout/wr/addr/addr_ok/data_ok interface that the core drives.

---
 rtl/sramlike_mem_responder_pkg.sv | 32 +++
 rtl/sramlike_mem_responder_if.sv | 15 +
 rtl/sramlike_resp_pipe.sv | 32 +++
 rtl/sramlike_mem_responder.sv | 71 +++++++
 tb/tb_sramlike_mem_responder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sramlike_mem_responder_pkg.sv
// Shared widths, request bundle and helpers for the SRAM-like memory responder.
package sramlike_mem_responder_pkg;
   localparam int unsigned SRAMLIKE_AW = 32;
   localparam int unsigned SRAMLIKE_DW = 32;
   localparam int unsigned SRAMLIKE_BW = 4;

   typedef logic [SRAMLIKE_AW-1:0] addr_t;
   typedef logic [SRAMLIKE_DW-1:0] word_t;
   typedef logic [SRAMLIKE_BW-1:0] be_t;

   typedef struct packed {
      logic  wr;
      be_t   ben;
      addr_t addr;
      word_t din;
   } req_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   function automatic word_t lane_merge(input word_t old_w, input word_t new_w, input be_t be);
      word_t w;
      w = old_w;
      for (int i = 0; i < SRAMLIKE_BW; i++)
         if (be[i]) w[8*i +: 8] = new_w[8*i +: 8];
      return w;
   endfunction

   // Fibonacci, taps 16,14,13,11, shifting toward the MSB.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction
endpackage

// File: rtl/sramlike_mem_responder_if.sv
// SRAM-like request/response bus: master drives requests, slave answers.
interface sramlike_mem_responder_if;
   import sramlike_mem_responder_pkg::*;

   be_t   ben;
   word_t din;
   logic  wr;
   addr_t addr;
   logic  addr_ok;
   word_t dout;
   logic  data_ok;

   modport master (output ben, din, wr, addr, input addr_ok, dout, data_ok);
   modport slave  (input ben, din, wr, addr, output addr_ok, dout, data_ok);
endinterface

// File: rtl/sramlike_resp_pipe.sv
// Fixed-depth valid/data shift register carrying responses from accept to data_ok.
module sramlike_resp_pipe
   import sramlike_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic  clk,
   input  logic  resetn,
   input  logic  in_vld,
   input  word_t in_data,
   output logic  out_vld,
   output word_t out_data
);
   localparam int unsigned STAGES = DEPTH - 1;

   logic  [STAGES:0] vld_pipe;
   word_t [STAGES:0] dat_pipe;

   // Bubbles carry zero data so dout idles at 0 between pulses.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
      end else begin
         vld_pipe <= DEPTH'({vld_pipe, in_vld});
         dat_pipe <= (DEPTH*SRAMLIKE_DW)'({dat_pipe, in_data});
      end
   end

   assign out_vld  = vld_pipe[STAGES];
   assign out_data = dat_pipe[STAGES];
endmodule

// File: rtl/sramlike_mem_responder.sv
// On-chip word memory behind an SRAM-like slave port: in-order single-beat
// accesses, fixed response latency, bounded outstanding count, optional LFSR stalls.
module sramlike_mem_responder
   import sramlike_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2      = 12,
   parameter int unsigned LATENCY         = 2,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned STALL_NUM       = 0
) (
   input  logic                   clk,
   input  logic                   resetn,
   sramlike_mem_responder_if.slave bus
);
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   req_t                  req;
   logic [DEPTH_LOG2-1:0] idx;
   word_t                 mem [2**DEPTH_LOG2];
   logic [15:0]           lfsr;
   logic [CW-1:0]         outstanding;
   logic                  run;
   logic                  stall;
   logic                  accept;
   logic                  rsp_vld;
   word_t                 rd_word;
   word_t                 rsp_data;
   logic                  unused_addr;

   assign req         = '{wr: bus.wr, ben: bus.ben, addr: bus.addr, din: bus.din};
   assign idx         = req.addr[DEPTH_LOG2+1:2];
   assign unused_addr = ^{req.addr[SRAMLIKE_AW-1:DEPTH_LOG2+2], req.addr[1:0]};

   // addr_ok looks only at registered state; run keeps it low while in reset.
   assign stall       = 32'(lfsr[3:0]) < STALL_NUM;
   assign bus.addr_ok = run && !stall && ((outstanding < CW'(MAX_OUTSTANDING)) || rsp_vld);
   assign accept      = bus.addr_ok && (req.ben != '0);
   assign rd_word     = (accept && !req.wr) ? mem[idx] : '0;

   always_ff @(posedge clk) begin
      if (accept && req.wr) mem[idx] <= lane_merge(mem[idx], req.din, req.ben);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr        <= LFSR_SEED;
         run         <= 1'b0;
         outstanding <= '0;
      end else begin
         lfsr <= lfsr_next(lfsr);
         run  <= 1'b1;
         case ({accept, rsp_vld})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   sramlike_resp_pipe #(.DEPTH(LATENCY)) u_pipe (
      .clk      (clk),
      .resetn   (resetn),
      .in_vld   (accept),
      .in_data  (rd_word),
      .out_vld  (rsp_vld),
      .out_data (rsp_data)
   );

   assign bus.data_ok = rsp_vld;
   assign bus.dout    = rsp_data;
endmodule

// File: tb/tb_sramlike_mem_responder.sv
// Directed bench: four responder configurations, responses logged per DUT and
// compared against hand-computed data and cycle numbers.
`timescale 1ns/1ps
module tb_sramlike_mem_responder;
   import sramlike_mem_responder_pkg::*;

   localparam int ND = 4;
   typedef struct { int cyc; word_t data; } rsp_t;

   logic  clk = 1'b0;
   logic  rst_n [ND] = '{default: 1'b0};
   be_t   drv_ben  [ND];
   logic  drv_wr   [ND];
   addr_t drv_addr [ND];
   word_t drv_din  [ND];
   logic  aok  [ND];
   logic  dok  [ND];
   word_t dout [ND];

   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   rsp_t rq [ND][$];
   int   n_dok [ND] = '{default: 0};
   int   stall_low = 0;
   int   stall_tot = 0;
   logic stall_win = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sramlike_mem_responder_if if_a (), if_b (), if_c (), if_d ();

   assign if_a.ben = drv_ben[0]; assign if_a.wr = drv_wr[0]; assign if_a.addr = drv_addr[0]; assign if_a.din = drv_din[0];
   assign if_b.ben = drv_ben[1]; assign if_b.wr = drv_wr[1]; assign if_b.addr = drv_addr[1]; assign if_b.din = drv_din[1];
   assign if_c.ben = drv_ben[2]; assign if_c.wr = drv_wr[2]; assign if_c.addr = drv_addr[2]; assign if_c.din = drv_din[2];
   assign if_d.ben = drv_ben[3]; assign if_d.wr = drv_wr[3]; assign if_d.addr = drv_addr[3]; assign if_d.din = drv_din[3];
   assign aok[0] = if_a.addr_ok; assign dok[0] = if_a.data_ok; assign dout[0] = if_a.dout;
   assign aok[1] = if_b.addr_ok; assign dok[1] = if_b.data_ok; assign dout[1] = if_b.dout;
   assign aok[2] = if_c.addr_ok; assign dok[2] = if_c.data_ok; assign dout[2] = if_c.dout;
   assign aok[3] = if_d.addr_ok; assign dok[3] = if_d.data_ok; assign dout[3] = if_d.dout;

   sramlike_mem_responder dut_a (.clk(clk), .resetn(rst_n[0]), .bus(if_a));
   sramlike_mem_responder #(.DEPTH_LOG2(8), .LATENCY(3), .MAX_OUTSTANDING(1))
      dut_b (.clk(clk), .resetn(rst_n[1]), .bus(if_b));
   sramlike_mem_responder #(.DEPTH_LOG2(4), .STALL_NUM(8))
      dut_c (.clk(clk), .resetn(rst_n[2]), .bus(if_c));
   sramlike_mem_responder #(.DEPTH_LOG2(6), .LATENCY(4), .MAX_OUTSTANDING(2))
      dut_d (.clk(clk), .resetn(rst_n[3]), .bus(if_d));

   always @(negedge clk) begin
      for (int d = 0; d < ND; d++)
         if (dok[d] === 1'b1) begin
            rq[d].push_back('{cyc, dout[d]});
            n_dok[d] <= n_dok[d] + 1;
         end
      if (stall_win) begin
         stall_tot <= stall_tot + 1;
         if (!aok[2]) stall_low <= stall_low + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one request and hold it until addr_ok; returns accept cycle and stall cycles.
   task automatic issue(input int d, input logic w, input be_t be, input addr_t a, input word_t dat,
                        output int acc, output int waits);
      bit got;
      got = 1'b0; waits = 0; acc = -1;
      drv_wr[d] = w; drv_ben[d] = be; drv_addr[d] = a; drv_din[d] = dat;
      while (!got && waits < 64) begin
         @(negedge clk);
         if (aok[d] === 1'b1) begin got = 1'b1; acc = cyc; end
         @(posedge clk); #1;
         if (!got) waits++;
      end
      drv_ben[d] = '0;
      if (!got) chk("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic pop_chk(input int d, input string tag, input word_t exp_data, input int exp_cyc);
      rsp_t r;
      if (rq[d].size() == 0) chk({tag, "_missing"}, 32'd0, 32'd1);
      else begin
         r = rq[d].pop_front();
         chk(tag, r.data, exp_data);
         if (exp_cyc >= 0) chk({tag, "_cyc"}, r.cyc, exp_cyc);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, a2, w0, w1, w2, n0;
      int acc8 [8];
      int wsum;
      word_t mdl [16];
      word_t eq [$];

      for (int d = 0; d < ND; d++) begin
         drv_ben[d] = '0; drv_wr[d] = 1'b0; drv_addr[d] = '0; drv_din[d] = '0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         chk("rst_addr_ok", 32'(aok[d]), 32'd0);
         chk("rst_data_ok", 32'(dok[d]), 32'd0);
         chk("rst_dout", dout[d], 32'd0);
      end
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) rst_n[d] = 1'b1;
      step(2);

      // basic write then read, latency 2
      issue(0, 1'b1, 4'hf, 32'h10, 32'hDEADBEEF, a0, w0);
      issue(0, 1'b0, 4'hf, 32'h10, 32'h0, a1, w1);
      chk("t1_wait_wr", w0, 0);
      chk("t1_wait_rd", w1, 0);
      chk("t1_b2b", a1, a0 + 1);
      step(4);
      pop_chk(0, "t1_wr_rsp", 32'h0, a0 + 2);
      pop_chk(0, "t1_rd_rsp", 32'hDEADBEEF, a0 + 3);

      // byte lanes
      rq[0].delete();
      issue(0, 1'b1, 4'hf, 32'h20, 32'h11223344, a0, w0);
      issue(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, a1, w1);
      issue(0, 1'b0, 4'hf, 32'h20, 32'h0, a2, w2);
      step(4);
      pop_chk(0, "t2_wr0", 32'h0, a0 + 2);
      pop_chk(0, "t2_wr1", 32'h0, a1 + 2);
      pop_chk(0, "t2_rd", 32'h11BB33DD, a2 + 2);

      // ben == 0 is idle even with wr and data on the bus
      n0 = n_dok[0];
      drv_wr[0] = 1'b1; drv_addr[0] = 32'h10; drv_din[0] = 32'hFFFFFFFF; drv_ben[0] = '0;
      step(5);
      chk("idle_no_rsp", n_dok[0] - n0, 0);
      rq[0].delete();
      issue(0, 1'b0, 4'hf, 32'h10, 32'h0, a0, w0);
      step(4);
      pop_chk(0, "idle_mem_kept", 32'hDEADBEEF, a0 + 2);

      // top word index aliased through ignored high and low address bits
      rq[0].delete();
      issue(0, 1'b1, 4'hf, 32'h3FFC, 32'h0BADF00D, a0, w0);
      issue(0, 1'b0, 4'hf, 32'h7FFE, 32'h0, a1, w1);
      step(4);
      pop_chk(0, "alias_wr", 32'h0, a0 + 2);
      pop_chk(0, "alias_rd", 32'h0BADF00D, a1 + 2);

      // MAX == LATENCY == 2: full rate streaming
      for (int i = 0; i < 8; i++) issue(0, 1'b1, 4'hf, 32'h100 + 32'(4*i), 32'hC0DE0000 + 32'(i), a0, w0);
      step(4);
      rq[0].delete();
      wsum = 0;
      for (int i = 0; i < 8; i++) begin
         issue(0, 1'b0, 4'hf, 32'h100 + 32'(4*i), 32'h0, acc8[i], w0);
         wsum += w0;
      end
      chk("t4_no_stall", wsum, 0);
      chk("t4_span", acc8[7], acc8[0] + 7);
      step(4);
      for (int i = 0; i < 8; i++) pop_chk(0, "t4_rd", 32'hC0DE0000 + 32'(i), acc8[i] + 2);

      // MAX_OUTSTANDING=1, LATENCY=3: one accept per 3 cycles
      issue(1, 1'b1, 4'hf, 32'h40, 32'h13579BDF, a0, w0);
      step(5);
      rq[1].delete();
      issue(1, 1'b0, 4'hf, 32'h40, 32'h0, a0, w0);
      issue(1, 1'b0, 4'hf, 32'h40, 32'h0, a1, w1);
      issue(1, 1'b0, 4'hf, 32'h40, 32'h0, a2, w2);
      chk("t3_wait0", w0, 0);
      chk("t3_wait1", w1, 2);
      chk("t3_wait2", w2, 2);
      chk("t3_acc1", a1, a0 + 3);
      chk("t3_acc2", a2, a0 + 6);
      step(5);
      pop_chk(1, "t3_rd0", 32'h13579BDF, a1);
      pop_chk(1, "t3_rd1", 32'h13579BDF, a2);
      pop_chk(1, "t3_rd2", 32'h13579BDF, a2 + 3);

      // write offered only while addr_ok is low, then withdrawn
      issue(1, 1'b0, 4'hf, 32'h40, 32'h0, a0, w0);
      drv_wr[1] = 1'b1; drv_ben[1] = 4'hf; drv_addr[1] = 32'h40; drv_din[1] = 32'hFFFFFFFF;
      @(negedge clk);
      chk("drop_addr_ok", 32'(aok[1]), 32'd0);
      @(posedge clk); #1;
      drv_ben[1] = '0;
      step(5);
      rq[1].delete();
      issue(1, 1'b0, 4'hf, 32'h40, 32'h0, a0, w0);
      step(5);
      pop_chk(1, "drop_no_effect", 32'h13579BDF, a0 + 3);

      // random traffic with 50% stalls against a scoreboard
      for (int i = 0; i < 16; i++) begin
         mdl[i] = $urandom;
         issue(2, 1'b1, 4'hf, 32'(i) << 2, mdl[i], a0, w0);
         eq.push_back(32'h0);
      end
      stall_win = 1'b1;
      for (int n = 0; n < 100; n++) begin
         logic  w;
         int    ix;
         be_t   be;
         word_t dat;
         addr_t a;
         w   = 1'($urandom_range(0, 1));
         ix  = $urandom_range(0, 15);
         be  = w ? 4'($urandom_range(1, 15)) : 4'hf;
         dat = $urandom;
         a   = ($urandom & 32'hFFFF_FFC0) | (32'(ix) << 2) | ($urandom & 32'h3);
         issue(2, w, be, a, dat, a0, w0);
         if (w) begin
            for (int b = 0; b < 4; b++) if (be[b]) mdl[ix][8*b +: 8] = dat[8*b +: 8];
            eq.push_back(32'h0);
         end else eq.push_back(mdl[ix]);
      end
      stall_win = 1'b0;
      step(6);
      chk("t5_count", rq[2].size(), eq.size());
      chk("t5_stall_ratio", 32'(stall_low * 100 >= stall_tot * 30 && stall_low * 100 <= stall_tot * 70), 32'd1);
      while (eq.size() > 0) pop_chk(2, "t5_data", eq.pop_front(), -1);

      // reset with two reads in flight
      issue(3, 1'b1, 4'hf, 32'h8, 32'h5A5A1234, a0, w0);
      step(6);
      rq[3].delete();
      n0 = n_dok[3];
      issue(3, 1'b0, 4'hf, 32'h8, 32'h0, a0, w0);
      issue(3, 1'b0, 4'hf, 32'h8, 32'h0, a1, w1);
      chk("t6_b2b", a1, a0 + 1);
      rst_n[3] = 1'b0;
      @(negedge clk);
      chk("t6_rst_addr_ok", 32'(aok[3]), 32'd0);
      chk("t6_rst_data_ok", 32'(dok[3]), 32'd0);
      step(3);
      rst_n[3] = 1'b1;
      step(6);
      chk("t6_dropped", n_dok[3] - n0, 0);
      issue(3, 1'b0, 4'hf, 32'h8, 32'h0, a0, w0);
      issue(3, 1'b0, 4'hf, 32'h8, 32'h0, a1, w1);
      chk("t6_wait0", w0, 0);
      chk("t6_wait1", w1, 0);
      step(6);
      pop_chk(3, "t6_rd0", 32'h5A5A1234, a0 + 4);
      pop_chk(3, "t6_rd1", 32'h5A5A1234, a1 + 4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
